// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt front end.
package interrupt_pkg;

    typedef enum logic [1:0] {
        VEC_NONE  = 2'b00,
        VEC_IRQ   = 2'b01,
        VEC_NMI   = 2'b10,
        VEC_RESET = 2'b11
    } vec_sel_t;

    localparam int unsigned SYNC_STAGES    = 2;
    localparam int unsigned RESET_HOLD_MAX = 15;
    localparam int unsigned HOLD_CNT_W     = $clog2(RESET_HOLD_MAX + 1);

    // Saturating increment so a long RESET hold never wraps back to "not armed".
    function automatic logic [HOLD_CNT_W-1:0] hold_inc(input logic [HOLD_CNT_W-1:0] cnt);
        return (cnt == HOLD_CNT_W'(RESET_HOLD_MAX)) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/pin_synchronizer.sv
// Multi-flop synchronizer for one asynchronous active-low pin; idles high.
import interrupt_pkg::*;

module pin_synchronizer (
    input  logic clk,
    input  logic nrst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_detect.sv
// RESET/NMI/IRQ pin detection and boundary arbitration.
// Optional macro INTERRUPT_POWER_ON_RESET_EN: issue a reset sequence after nrst release.
import interrupt_pkg::*;

module interrupt_detect #(
    parameter int unsigned RESET_HOLD_CYCLES = 2
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       enableFFs,
    input  logic       nResetPin,
    input  logic       nNmiPin,
    input  logic       nIrqPin,
    input  logic       processStatusRegIFlag,
    input  logic       instructionBoundary,
    output logic       resetInitiated,
    output logic       nmiInitiated,
    output logic       irqInitiated,
    output logic [1:0] vectorSelect,
    output logic       interruptPending
);

`ifdef INTERRUPT_POWER_ON_RESET_EN
    localparam logic     POR_PENDING = 1'b1;
    localparam vec_sel_t POR_VEC     = VEC_RESET;
`else
    localparam logic     POR_PENDING = 1'b0;
    localparam vec_sel_t POR_VEC     = VEC_NONE;
`endif

    localparam logic [HOLD_CNT_W-1:0] HOLD_LIMIT = HOLD_CNT_W'(RESET_HOLD_CYCLES);

    logic w_reset_s, w_nmi_s, w_irq_s;

    pin_synchronizer u_sync_reset (.clk(clk), .nrst(nrst), .i_async(nResetPin), .o_sync(w_reset_s));
    pin_synchronizer u_sync_nmi   (.clk(clk), .nrst(nrst), .i_async(nNmiPin),   .o_sync(w_nmi_s));
    pin_synchronizer u_sync_irq   (.clk(clk), .nrst(nrst), .i_async(nIrqPin),   .o_sync(w_irq_s));

    logic [HOLD_CNT_W-1:0] r_hold_cnt;
    logic                  r_nmi_prev;
    logic                  r_reset_pending;
    logic                  r_nmi_pending;
    vec_sel_t              r_vec;
    logic                  r_reset_init, r_nmi_init, r_irq_init;

    logic w_reset_release, w_nmi_edge, w_irq_active;
    logic w_take_reset, w_take_nmi, w_take_irq;

    assign w_reset_release = w_reset_s && (r_hold_cnt >= HOLD_LIMIT);
    assign w_nmi_edge      = r_nmi_prev && !w_nmi_s;
    assign w_irq_active    = !w_irq_s && !processStatusRegIFlag;

    assign w_take_reset = instructionBoundary && r_reset_pending;
    assign w_take_nmi   = instructionBoundary && !r_reset_pending && r_nmi_pending;
    assign w_take_irq   = instructionBoundary && !r_reset_pending && !r_nmi_pending && w_irq_active;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_hold_cnt      <= '0;
            r_nmi_prev      <= 1'b1;
            r_reset_pending <= POR_PENDING;
            r_nmi_pending   <= 1'b0;
            r_vec           <= POR_VEC;
            r_reset_init    <= 1'b0;
            r_nmi_init      <= 1'b0;
            r_irq_init      <= 1'b0;
        end else begin
            r_reset_init <= 1'b0;
            r_nmi_init   <= 1'b0;
            r_irq_init   <= 1'b0;
            if (enableFFs) begin
                r_hold_cnt <= w_reset_s ? '0 : hold_inc(r_hold_cnt);
                r_nmi_prev <= w_nmi_s;
                if (w_take_reset) begin
                    r_reset_pending <= 1'b0;
                    r_nmi_pending   <= 1'b0;
                    r_reset_init    <= 1'b1;
                    r_vec           <= VEC_RESET;
                end else if (w_take_nmi) begin
                    r_nmi_pending <= 1'b0;
                    r_nmi_init    <= 1'b1;
                    r_vec         <= VEC_NMI;
                end else if (w_take_irq) begin
                    r_irq_init <= 1'b1;
                    r_vec      <= VEC_IRQ;
                end
                // New events come after the clears so a coinciding edge/release survives.
                if (w_reset_release) r_reset_pending <= 1'b1;
                if (w_nmi_edge)      r_nmi_pending   <= 1'b1;
            end
        end
    end

    assign resetInitiated   = r_reset_init;
    assign nmiInitiated     = r_nmi_init;
    assign irqInitiated     = r_irq_init;
    assign vectorSelect     = r_vec;
    assign interruptPending = r_reset_pending || r_nmi_pending || w_irq_active;

endmodule

// File: tb/tb_interrupt_detect.sv
// Directed, self-checking bench for interrupt_detect (both INTERRUPT_POWER_ON_RESET_EN builds).
module tb_interrupt_detect;

`ifdef INTERRUPT_POWER_ON_RESET_EN
    localparam logic       POR      = 1'b1;
    localparam logic [1:0] BASE_VEC = 2'b11;
`else
    localparam logic       POR      = 1'b0;
    localparam logic [1:0] BASE_VEC = 2'b00;
`endif

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       enableFFs = 1'b1;
    logic       nResetPin = 1'b1, nNmiPin = 1'b1, nIrqPin = 1'b1;
    logic       processStatusRegIFlag = 1'b1;
    logic       instructionBoundary = 1'b0;
    logic       resetInitiated, nmiInitiated, irqInitiated, interruptPending;
    logic [1:0] vectorSelect;

    int n_tests = 0;
    int n_fail  = 0;

    interrupt_detect #(.RESET_HOLD_CYCLES(2)) dut (
        .clk(clk), .nrst(nrst), .enableFFs(enableFFs),
        .nResetPin(nResetPin), .nNmiPin(nNmiPin), .nIrqPin(nIrqPin),
        .processStatusRegIFlag(processStatusRegIFlag),
        .instructionBoundary(instructionBoundary),
        .resetInitiated(resetInitiated), .nmiInitiated(nmiInitiated),
        .irqInitiated(irqInitiated), .vectorSelect(vectorSelect),
        .interruptPending(interruptPending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       nirq;
        logic       iflag;
        logic       bnd;
        logic       exp_irq;
        logic [1:0] exp_vec;
        logic       exp_pend;
    } irq_row_t;

    irq_row_t tbl[12];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One rising edge, then return to the falling edge for checking/driving.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        enableFFs = 1'b1; nResetPin = 1'b1; nNmiPin = 1'b1; nIrqPin = 1'b1;
        processStatusRegIFlag = 1'b1; instructionBoundary = 1'b0;
    endtask

    // Reset and flush any power-on reset request so every group starts quiet.
    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        nrst = 1'b0;
        cycle(); cycle();
        nrst = 1'b1;
        instructionBoundary = 1'b1; cycle();
        instructionBoundary = 1'b0; cycle();
    endtask

    int cnt;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, BASE_VEC, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, BASE_VEC, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, BASE_VEC, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, BASE_VEC, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b01,    1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01,    1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b01,    1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b01,    1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01,    1'b1};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'b01,    1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 2'b01,    1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b01,    1'b0};

        // Power-on reset behaviour
        idle_inputs();
        cycle(); cycle();
        chk("rst_vec", vectorSelect, BASE_VEC);
        chk("rst_pulses", {resetInitiated, nmiInitiated, irqInitiated}, 3'b000);
        chk("rst_pending", interruptPending, POR);
        nrst = 1'b1;
        cycle(); cycle();
        chk("por_no_early", resetInitiated, 1'b0);
        instructionBoundary = 1'b1; cycle();
        chk("por_pulse", resetInitiated, POR);
        chk("por_vec", vectorSelect, BASE_VEC);
        instructionBoundary = 1'b0; cycle();
        chk("por_pulse_end", resetInitiated, 1'b0);
        chk("por_pending_clr", interruptPending, 1'b0);

        // IRQ masking / level behaviour, table driven
        do_reset();
        for (int i = 0; i < 12; i++) begin
            nIrqPin = tbl[i].nirq;
            processStatusRegIFlag = tbl[i].iflag;
            instructionBoundary = tbl[i].bnd;
            cycle();
            chk($sformatf("irq_pulse[%0d]", i), irqInitiated, tbl[i].exp_irq);
            chk($sformatf("irq_vec[%0d]", i), vectorSelect, tbl[i].exp_vec);
            chk($sformatf("irq_pend[%0d]", i), interruptPending, tbl[i].exp_pend);
        end

        // RESET pin shorter than the hold count is ignored
        do_reset();
        nResetPin = 1'b0; cycle();
        nResetPin = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        chk("rst_short_pend", interruptPending, 1'b0);
        instructionBoundary = 1'b1; cycle();
        chk("rst_short_pulse", resetInitiated, 1'b0);
        instructionBoundary = 1'b0;

        // RESET held long enough, taken only after release
        nResetPin = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("rst_held_no_pend", interruptPending, 1'b0);
        nResetPin = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("rst_long_pend", interruptPending, 1'b1);
        chk("rst_long_nopulse", resetInitiated, 1'b0);
        instructionBoundary = 1'b1; cycle();
        chk("rst_long_pulse", resetInitiated, 1'b1);
        chk("rst_long_vec", vectorSelect, 2'b11);
        instructionBoundary = 1'b0; cycle();
        chk("rst_long_end", {resetInitiated, interruptPending}, 2'b00);

        // NMI is edge sensitive: one request per falling edge
        do_reset();
        cnt = 0;
        nNmiPin = 1'b0;
        for (int i = 0; i < 20; i++) begin
            instructionBoundary = (i % 4 == 3);
            cycle();
            if (nmiInitiated) cnt++;
        end
        chk("nmi_level_once", 8'(cnt), 8'd1);
        chk("nmi_vec", vectorSelect, 2'b10);
        instructionBoundary = 1'b0;
        nNmiPin = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        nNmiPin = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            instructionBoundary = (i % 4 == 3);
            cycle();
            if (nmiInitiated) cnt++;
        end
        chk("nmi_reassert", 8'(cnt), 8'd1);
        instructionBoundary = 1'b0;

        // Priority: reset beats NMI and IRQ, and clears NMI
        do_reset();
        nResetPin = 1'b0; nNmiPin = 1'b0; nIrqPin = 1'b0; processStatusRegIFlag = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        nResetPin = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        instructionBoundary = 1'b1; cycle();
        chk("prio_pulses", {resetInitiated, nmiInitiated, irqInitiated}, 3'b100);
        chk("prio_vec", vectorSelect, 2'b11);
        processStatusRegIFlag = 1'b1; cycle();
        chk("prio_nmi_cleared", {resetInitiated, nmiInitiated, irqInitiated}, 3'b000);
        chk("prio_pending", interruptPending, 1'b0);
        instructionBoundary = 1'b0;

        // NMI edge coinciding with NMI arbitration keeps the request
        do_reset();
        nNmiPin = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        nNmiPin = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        nNmiPin = 1'b0;
        cycle(); cycle();
        instructionBoundary = 1'b1; cycle();
        chk("coll_first", nmiInitiated, 1'b1);
        instructionBoundary = 1'b0; cycle();
        chk("coll_first_end", nmiInitiated, 1'b0);
        chk("coll_still_pend", interruptPending, 1'b1);
        instructionBoundary = 1'b1; cycle();
        chk("coll_second", nmiInitiated, 1'b1);
        cycle();
        chk("coll_no_third", {nmiInitiated, interruptPending}, 2'b00);
        instructionBoundary = 1'b0;

        // Enable gating holds pending and suppresses pulses
        do_reset();
        nNmiPin = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        enableFFs = 1'b0; instructionBoundary = 1'b1;
        cycle(); cycle();
        chk("gate_nopulse", nmiInitiated, 1'b0);
        chk("gate_pend_held", interruptPending, 1'b1);
        chk("gate_vec_held", vectorSelect, BASE_VEC);
        enableFFs = 1'b1; instructionBoundary = 1'b0; cycle();
        chk("gate_reen_nopulse", nmiInitiated, 1'b0);
        instructionBoundary = 1'b1; cycle();
        chk("gate_pulse", nmiInitiated, 1'b1);
        enableFFs = 1'b0; cycle();
        chk("gate_pulse_drops", nmiInitiated, 1'b0);
        chk("gate_vec_nmi", vectorSelect, 2'b10);
        enableFFs = 1'b1; instructionBoundary = 1'b0;

        // Asynchronous reset aborts pending state without a clock edge
        nNmiPin = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        nNmiPin = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("async_pre", interruptPending, 1'b1);
        #2 nrst = 1'b0;
        #1;
        chk("async_pending", interruptPending, POR);
        chk("async_vec", vectorSelect, BASE_VEC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
